// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg: shared types and constants for the instruction-fetch front end.
//   fetch_state_e : FETCH (issue allowed) / DRAIN (discard stale responses)
//   fetch_entry_t : one buffered fetch result {pc, instr}
//   INSTR_NOP     : canonical addi x0,x0,0 encoding for bubble insertion
//   word_align    : clears bits [1:0] of a byte address
// ----------------------------------------------------------------------------
package if_pkg;

    localparam int          IF_XLEN          = 32;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [IF_XLEN-1:0] word_align(input logic [IF_XLEN-1:0] a);
        return {a[IF_XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo: generic single-clock FIFO, first-word-fall-through read port.
//   clk, rst (sync, active-low), clear (drops all entries, wins over push)
//   push/wdata : write when not full, or when full and popping this cycle
//   pop/rdata  : rdata always shows the head; pop ignored when empty
//   full/empty/count : occupancy status
// DEPTH must be a power of two; pointers carry one extra wrap bit.
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             do_push, do_pop;

    assign count   = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    // Full + pop frees the head slot this edge, so the write can take it.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// ----------------------------------------------------------------------------
// if_prefetch_queue: IF-stage prefetcher for the 5-stage RV32 core.
// Owns the fetch PC, issues word fetches with credit-based flow control so
// the entry FIFO never overflows, and presents {pc, pc+4, instr} to IF/ID.
// EX redirects flush the FIFO; responses already in flight are discarded
// by counting them down in DRAIN.
//   clk, rst (sync, active-low)
//   imem_req_valid/ready/addr : fetch request channel
//   imem_rsp_valid/data       : in-order fetch responses
//   redirect_valid/pc         : EX-stage redirect
//   out_valid/ready, out_pc, out_pc_plus4, out_instr : to IF/ID
// Optional: define IF_PREFETCH_BYPASS_EN to forward a response straight to
// decode when the FIFO is empty (zero-cycle response latency).
// ----------------------------------------------------------------------------
module if_prefetch_queue
    import if_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic [XLEN-1:0] out_instr
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] tag_pc;     // PC of the oldest live outstanding fetch
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   drop_nx;

    fetch_entry_t    fifo_wdata, fifo_rdata, head;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;

    logic            req_fire, rsp_live, credit_ok;

    // Buffered entries plus outstanding fetches bound the occupancy.
    assign credit_ok      = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(DEPTH);
    assign imem_req_valid = rst && (state == FETCH) && credit_ok && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response landing with a redirect belongs to the old stream.
    assign rsp_live   = imem_rsp_valid && (state == FETCH) && !redirect_valid;
    assign drop_nx    = inflight - CW'(imem_rsp_valid);
    assign fifo_wdata = '{pc: tag_pc, instr: imem_rsp_data};

`ifdef IF_PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass    = fifo_empty && (state == FETCH) && imem_rsp_valid;
    assign head      = bypass ? fifo_wdata : fifo_rdata;
    assign out_valid = rst && !redirect_valid && (!fifo_empty || bypass);
    assign fifo_push = rsp_live && !(bypass && out_ready);
    assign fifo_pop  = out_valid && out_ready && !fifo_empty;
`else
    assign head      = fifo_rdata;
    assign out_valid = rst && !fifo_empty && !redirect_valid;
    assign fifo_push = rsp_live;
    assign fifo_pop  = out_valid && out_ready;
`endif

    assign out_pc       = head.pc;
    assign out_pc_plus4 = head.pc + 32'd4;
    assign out_instr    = head.instr;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect_valid),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            tag_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;

            if (redirect_valid) begin
                fetch_pc <= word_align(redirect_pc);
                tag_pc   <= word_align(redirect_pc);
                drop     <= drop_nx;
                state    <= (drop_nx != '0) ? DRAIN : FETCH;
            end else if (state == DRAIN) begin
                if (imem_rsp_valid) begin
                    drop <= drop - 1'b1;
                    if (drop == CW'(1)) state <= FETCH;
                end
            end else if (rsp_live) begin
                tag_pc <= tag_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// ----------------------------------------------------------------------------
// tb_if_prefetch_queue: directed scenarios followed by a randomized soak.
// The reference treats the design as "a stream of sequential PCs restarted
// by redirects/reset": each fetch is tagged with the stream epoch it was
// issued in, only current-epoch responses become visible entries, and the
// request credit is derived from entries + outstanding fetches.
// ----------------------------------------------------------------------------
module tb_if_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_pc, out_pc_plus4, out_instr;

    always #5 clk = ~clk;

    if_prefetch_queue #(.DEPTH(DEPTH), .XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .out_instr      (out_instr)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          epoch  = 0;
    req_t        mq[$];          // outstanding fetches, in order
    logic [31:0] fq[$];          // visible entries (pc only; instr from memf)
    logic [31:0] mpc = RESET_PC; // next address the stream will fetch
    logic [31:0] popped[$];      // DUT out_pc on each accepted entry
    logic [31:0] fired[$];       // DUT imem_req_addr on each accepted request

    // stimulus knobs
    logic        d_rst = 1'b0, d_redirect = 1'b0, d_out_ready = 1'b1, d_req_ready = 1'b1;
    logic [31:0] d_redirect_pc = '0;
    int          lat_min = 1, lat_max = 1, rsp_pct = 100;

    // Instruction memory contents: address-derived so pc/instr swaps show.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_first(input string nm, input logic [31:0] q[$], input logic [31:0] exp);
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s actual=none required=%h", nm, exp);
        end else begin
            check(nm, q[0], exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare against the model, then
    // advance the model to what must hold after the next rising edge.
    task automatic step();
        int   stale;
        logic exp_rv, exp_ov, rsp;
        @(negedge clk);
        rst            = d_rst;
        redirect_valid = d_redirect;
        redirect_pc    = d_redirect_pc;
        out_ready      = d_out_ready;
        imem_req_ready = d_req_ready;
        rsp = d_rst && (mq.size() > 0) && (mq[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memf(mq[0].addr) : $urandom;
        #1;
        stale = 0;
        foreach (mq[i]) if (mq[i].epoch != epoch) stale++;
        exp_rv = d_rst && !d_redirect && (stale == 0) && (fq.size() + mq.size() < DEPTH);
        exp_ov = d_rst && !d_redirect && (fq.size() > 0);
        check("req_valid", imem_req_valid, exp_rv);
        check("out_valid", out_valid, exp_ov);
        if (exp_rv) check("req_addr", imem_req_addr, mpc);
        if (exp_ov) begin
            check("out_pc", out_pc, fq[0]);
            check("out_pc_plus4", out_pc_plus4, fq[0] + 32'd4);
            check("out_instr", out_instr, memf(fq[0]));
        end

        if (!d_rst) begin
            mq.delete();
            fq.delete();
            mpc = RESET_PC;
            epoch++;
        end else begin
            if (exp_ov && d_out_ready) begin
                popped.push_back(out_pc);
                void'(fq.pop_front());
            end
            if (rsp) begin
                req_t h = mq.pop_front();
                if (h.epoch == epoch && !d_redirect) fq.push_back(h.addr);
            end
            if (exp_rv && d_req_ready) begin
                fired.push_back(imem_req_addr);
                mq.push_back('{addr: mpc, epoch: epoch, due: cyc + $urandom_range(lat_max, lat_min)});
                mpc = mpc + 32'd4;
            end
            if (d_redirect) begin
                fq.delete();
                epoch++;
                mpc = d_redirect_pc & ~32'd3;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        d_rst = 1'b0;
        run(n);
        d_rst = 1'b1;
    endtask

    task automatic redirect_once(input logic [31:0] pc);
        d_redirect    = 1'b1;
        d_redirect_pc = pc;
        step();
        d_redirect    = 1'b0;
    endtask

    initial begin
        int bad;

        // Reset release with a 1-cycle memory, decode always ready.
        do_reset(2);
        popped.delete();
        run(12);
        if (popped.size() < 4) begin
            checks++; errors++;
            $display("FAIL fill_count actual=%0d required=4", popped.size());
        end else begin
            check("fill_pc0", popped[0], 32'h0);
            check("fill_pc1", popped[1], 32'h4);
            check("fill_pc2", popped[2], 32'h8);
            check("fill_pc3", popped[3], 32'hC);
        end
        popped.delete();
        run(6);
        check("throughput", popped.size(), 6);

        // Decode stalled: credit stops issue at DEPTH.
        do_reset(2);
        d_out_ready = 1'b0;
        fired.delete();
        run(10);
        check("stall_reqs", fired.size(), DEPTH);
        check("stall_req_valid", imem_req_valid, 1'b0);
        d_out_ready = 1'b1;
        popped.delete();
        run(8);
        if (popped.size() < 4) begin
            checks++; errors++;
            $display("FAIL stall_drain_count actual=%0d required=4", popped.size());
        end else begin
            check("stall_pc0", popped[0], 32'h0);
            check("stall_pc1", popped[1], 32'h4);
            check("stall_pc2", popped[2], 32'h8);
            check("stall_pc3", popped[3], 32'hC);
        end

        // Redirect with fetches outstanding (3-cycle memory).
        do_reset(1);
        lat_min = 3; lat_max = 3;
        run(5);
        redirect_once(32'h100);
        popped.delete();
        run(20);
        check_first("redir_first_pc", popped, 32'h100);
        bad = 0;
        foreach (popped[i]) if (popped[i] >= 32'h10 && popped[i] <= 32'h18) bad++;
        check("redir_no_stale", bad, 0);

        // Unaligned redirect target.
        fired.delete();
        redirect_once(32'h203);
        run(15);
        check_first("align_first_req", fired, 32'h200);

        // Redirect coinciding with a response, then a second one while draining.
        lat_min = 2; lat_max = 2;
        run(6);
        for (int i = 0; i < 20; i++) begin
            if (mq.size() > 0 && mq[0].due <= cyc) break;
            step();
        end
        redirect_once(32'h180);
        redirect_once(32'h300);
        popped.delete();
        run(15);
        check_first("drain_redir_pc", popped, 32'h300);

        // Reset mid-stream with entries buffered.
        lat_min = 1; lat_max = 1;
        run(6);
        d_out_ready = 1'b0;
        run(3);
        do_reset(1);
        d_out_ready = 1'b1;
        fired.delete();
        popped.delete();
        step();
        check("post_reset_out_valid", out_valid, 1'b0);
        run(8);
        check_first("restart_req", fired, RESET_PC);
        check_first("restart_pop", popped, RESET_PC);

        // Request channel toggling ready every cycle.
        for (int i = 0; i < 20; i++) begin
            d_req_ready = i[0];
            step();
        end
        d_req_ready = 1'b1;

        // Randomized soak.
        lat_min = 1; lat_max = 4; rsp_pct = 80;
        for (int i = 0; i < 3000; i++) begin
            d_out_ready   = ($urandom_range(3) != 0);
            d_req_ready   = ($urandom_range(2) != 0);
            d_redirect    = ($urandom_range(39) == 0);
            d_redirect_pc = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                     : ($urandom & 32'h0000_0FFF);
            d_rst         = ($urandom_range(499) != 0);
            step();
        end
        d_redirect = 1'b0;
        d_rst      = 1'b1;
        run(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
